// File: rtl/string_to_board.sv
// ASCII-to-board parser: turns a byte stream of 16 decimal tile values into the
// packed 320-bit board vector (cell k at board[k*CELL_W +: CELL_W]).
module string_to_board #(
  parameter int CELL_W     = 20,
  parameter int NUM_CELLS  = 16,
  parameter int MAX_DIGITS = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  char_in,
  input  logic                        char_valid,
  output logic [NUM_CELLS*CELL_W-1:0] board,
  output logic [4:0]                  cells_loaded,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int BOARD_W = NUM_CELLS * CELL_W;
  localparam int DIG_W   = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W   = $clog2(NUM_CELLS);

  localparam logic [DIG_W-1:0] MAX_DIG   = DIG_W'(MAX_DIGITS);
  localparam logic [4:0]       LAST_CELL = 5'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    NUM  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BOARD_W-1:0]  board_q, board_d;
  logic [BOARD_W-1:0]  shadow_q, shadow_d;
  logic [CELL_W-1:0]   acc_q, acc_d;
  logic [DIG_W-1:0]    ndig_q, ndig_d;
  logic [4:0]          cells_q, cells_d;

  logic                is_digit;
  logic                is_esc;
  logic [CELL_W-1:0]   digit_val;
  logic [IDX_W-1:0]    wr_idx;

  assign is_digit  = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_esc    = (char_in == 8'h1B);
  assign digit_val = CELL_W'(char_in[3:0]);
  assign wr_idx    = cells_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      board_q  <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      ndig_q   <= '0;
      cells_q  <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      ndig_q   <= ndig_d;
      cells_q  <= cells_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    ndig_d   = ndig_q;
    cells_d  = cells_q;

    // start outranks any byte presented in the same cycle; that byte is dropped
    if (start) begin
      state_d  = SKIP;
      shadow_d = '0;
      acc_d    = '0;
      ndig_d   = '0;
      cells_d  = '0;
    end else if (char_valid) begin
      case (state_q)
        SKIP: begin
          if (is_digit) begin
            acc_d   = digit_val;
            ndig_d  = DIG_W'(1);
            state_d = NUM;
          end else if (is_esc) begin
            state_d = ERR;
          end
        end
        NUM: begin
          if (is_digit) begin
            if (ndig_q == MAX_DIG) begin
              state_d = ERR;
            end else begin
              acc_d  = acc_q * CELL_W'(10) + digit_val;
              ndig_d = ndig_q + DIG_W'(1);
            end
          end else if (is_esc) begin
            state_d = ERR;
          end else begin
            shadow_d[wr_idx*CELL_W +: CELL_W] = acc_q;
            cells_d = cells_q + 5'd1;
            acc_d   = '0;
            ndig_d  = '0;
            // the last cell goes straight into the committed board
            if (cells_q == LAST_CELL) begin
              board_d = shadow_d;
              state_d = IDLE;
            end else begin
              state_d = SKIP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign board        = board_q;
  assign cells_loaded = cells_q;
  assign busy         = (state_q == SKIP) || (state_q == NUM);
  assign done         = (state_q == IDLE);
  assign error        = (state_q == ERR);

endmodule

// File: doc/string_to_board.md
Name: string_to_board

Overview:
- ASCII-to-board parser; the inverse of the board text printer.
- Accepts a character stream (UART RX byte path, one byte per valid strobe) holding 16 decimal tile values and packs them into the 320-bit board vector used by the game core.
- Used to load test positions and saved games.
- Cell order and packing match the printer: cell k = rw*4+cl at board[k*20 +: 20].

Parameters:
- CELL_W, 20, width of one tile value in bits.
- NUM_CELLS, 16, number of tiles parsed per board.
- MAX_DIGITS, 6, maximum decimal digits per tile value; 999999 < 2^20.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new parse.
- char_in  input  8  ASCII byte.
- char_valid  input  1  char_in is valid this cycle; one byte consumed per asserted cycle.
- board  output  NUM_CELLS*CELL_W (320)  last successfully parsed board.
- cells_loaded  output  5  number of tiles completed in the current parse.
- busy  output  1  parse in progress.
- done  output  1  board committed; level.
- error  output  1  parse aborted; level.

Behaviour:
- Reset (async, rst_n=0):
  - board=0, cells_loaded=0, busy=0, done=1, error=0, state IDLE.
  - Shadow register, accumulator and digit count cleared.
- States: IDLE, SKIP, NUM, ERR. done is 1 in IDLE.
- Character classes:
  - Digit: 0x30-0x39.
  - ESC (0x1B): abort.
  - Every other byte is a separator (space, '|', '-', '\n', '\r', ',', letters, etc.).
- start (any state): next cycle state=SKIP, busy=1, done=0, error=0, cells_loaded=0, accumulator=0, digit count=0, shadow cleared. board keeps its old value.
- start and char_valid in the same cycle: start wins and the byte is dropped.
- IDLE/ERR: char_valid ignored; outputs hold.
- SKIP:
  - separator: no change.
  - digit: accumulator=digit value, digit count=1, go to NUM.
  - ESC: go to ERR.
- NUM:
  - digit with count<MAX_DIGITS: accumulator=accumulator*10+digit, count+1.
  - digit with count==MAX_DIGITS: go to ERR (overflow).
  - separator: write accumulator to shadow cell cells_loaded, cells_loaded+1, go to SKIP.
  - When that write completes cell NUM_CELLS-1, instead commit: board<=shadow including this cell; done=1, busy=0, go to IDLE. All of this is visible the cycle after the terminating byte.
  - ESC: go to ERR.
- A number needs a trailing separator; a final value without a terminator is never committed.
- ERR: error=1, busy=0, done=0, board unchanged, cells_loaded frozen. Exit only via start or reset.
- Leading zeros are legal and count as digits: "0002" = 2.
- Value 0 is written as "0". No blank-cell token.
- Arithmetic: accumulator is CELL_W bits. With MAX_DIGITS=6, *10+d never exceeds 999999, so no wrap.
- Throughput: one byte per clock, back-to-back char_valid supported. No backpressure.
- Reset mid-parse: immediate return to reset values; partial shadow discarded.

Test Plan:
- Reset then idle -> board=0, done=1, busy=0, error=0, cells_loaded=0.
- start, then "2 4 8 16 32 64 128 256 512 1024 2048 4096 8192 16384 32768 65536\r" back-to-back -> cell0=2 … cell15=65536, i.e. board[319:300]=65536 and board[19:0]=2; done=1 the cycle after '\r'; cells_loaded=16.
- start, then printer-format text "|   2|   0|..." with '-' lines, '|' and CRLF, 16 values -> identical packing; leading zeros accepted ("0002"→2); separators produce no cells.
- start, then "1234567 " -> error=1 on the 7th digit; board keeps the previous value; later chars ignored; a new start clears error.
- start, 5 values, then ESC -> error=1, cells_loaded=5, board unchanged. start plus a full 16-value string -> done=1 with the new board.
- Reset asserted after 10 cells -> all outputs at reset values; start with char_valid the same cycle -> byte dropped, parse begins on the next byte.
